freq_recip_ctrl: RTL and testbench
==================================

FREQ_RECIP_CTRL -- requirements
Module: freq_recip_ctrl

Interface
REQ-001 CLK_HZ, 50_000_000, clock frequency in Hz.
REQ-002 N_PERIODS, 10, signal periods per measurement; CLK_HZ*N_PERIODS SHALL be at most 2^32-1.
REQ-003 TIMEOUT_CYCLES, 50_000_000, maximum clk cycles spent in ARM plus MEASURE before abort.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 sig_in  in  1  asynchronous signal under test.
REQ-007 enable  in  1  level; high = measure continuously.
REQ-008 div_start  out  1  one-cycle divide request to the downstream divider.
REQ-009 div_dividend  out  32  dividend presented with div_start.
REQ-010 div_divisor  out  32  divisor presented with div_start.
REQ-011 div_quotient  in  32  rounded quotient from the divider.
REQ-012 div_ready  in  1  one-cycle result strobe from the divider.
REQ-013 freq_out  out  32  last result in Hz.
REQ-014 freq_valid  out  1  one-cycle strobe when freq_out updates.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout_flag  out  1  high when the last result came from a timeout.

Function
REQ-017 sig_in SHALL pass a 2-FF synchronizer; a rising-edge pulse (edge_p) SHALL be a 1-cycle pulse on synchronized 0->1, so minimum resolvable period is 2 clk cycles.
REQ-018 FSM states: IDLE, ARM, MEASURE, REQ, WAIT, DONE.
REQ-019 IDLE: enable=1 -> ARM; otherwise remain.
REQ-020 ARM: on edge_p -> cycle_cnt<=0, edge_cnt<=0, MEASURE.
REQ-021 MEASURE: cycle_cnt increments every cycle; edge_p increments edge_cnt; on edge_p with edge_cnt==N_PERIODS-1 -> div_divisor<=cycle_cnt+1, div_dividend<=CLK_HZ*N_PERIODS, REQ; a signal of exactly P clk cycles period SHALL yield divisor N_PERIODS*P.
REQ-022 A timeout counter SHALL clear on leaving IDLE/DONE and count every cycle in ARM and MEASURE; on reaching TIMEOUT_CYCLES -> freq_out<=0, timeout_flag<=1, freq_valid pulse, DONE.
REQ-023 Completion (REQ-021) and timeout in the same cycle: completion wins.
REQ-024 REQ: div_start=1 exactly one cycle -> WAIT; div_dividend/div_divisor SHALL hold stable from REQ until the next REQ.
REQ-025 WAIT: on div_ready -> freq_out<=div_quotient, timeout_flag<=0, freq_valid pulse next cycle, DONE; the divider responds 5 cycles after div_start (start in cycle T -> ready in T+5).
REQ-026 div_ready outside WAIT SHALL be ignored.
REQ-027 DONE: one cycle; enable=1 -> ARM, else IDLE.
REQ-028 enable=0 in any state SHALL return to IDLE at the next edge with no freq_valid; freq_out and timeout_flag keep prior values.
REQ-029 Counters SHALL be 32-bit; cycle_cnt saturates at 2^32-1.
REQ-030 freq_valid and div_start SHALL never be high outside their defined single cycles.

Reset
REQ-031 rst SHALL force IDLE, div_start=0, div_dividend=0, div_divisor=0, freq_out=0, freq_valid=0, busy=0, timeout_flag=0, synchronizer and all counters 0, in any state including WAIT.
REQ-032 A div_ready arriving after a mid-WAIT reset SHALL not update freq_out.

Verification
REQ-033 Defaults, rounding 5-cycle divider model, sig_in period 50 cycles, enable=1 -> div_divisor=500, div_dividend=500_000_000, freq_out=1_000_000, freq_valid 1 cycle, timeout_flag=0.
REQ-034 Period 7 cycles -> div_divisor=70, freq_out=7_142_857; period 2 cycles -> divisor 20, freq_out=25_000_000.
REQ-035 TIMEOUT_CYCLES=1000, sig_in held 0 -> freq_out=0, timeout_flag=1, freq_valid once, then ARM again.
REQ-036 enable dropped mid-MEASURE -> IDLE next cycle, no div_start, freq_out unchanged; re-enable -> normal result.
REQ-037 rst asserted 2 cycles after div_start -> all outputs at reset values; following div_ready ignored, freq_valid stays 0.
REQ-038 Back-to-back: 3 consecutive results at period 50 -> three freq_valid pulses, each 1_000_000, div_start exactly once per result.

Source files
------------

// File: rtl/freq_recip_ctrl.sv
// freq_recip_ctrl: reciprocal frequency counter controller driving an external divider.
// Times N_PERIODS input periods in clk cycles, then asks the divider for CLK_HZ*N_PERIODS / cycles.
module freq_recip_ctrl #(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned N_PERIODS      = 10,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sig_in,
    input  logic        enable,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic        div_ready,
    output logic [31:0] freq_out,
    output logic        freq_valid,
    output logic        busy,
    output logic        timeout_flag
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_MEASURE, S_REQ, S_WAIT, S_DONE} state_t;
    localparam logic [31:0] DIVIDEND = 32'(CLK_HZ * N_PERIODS);
    state_t      r_state, w_next;
    logic [2:0]  r_sync;
    logic [31:0] r_cyc_cnt, r_edge_cnt, r_to_cnt;
    logic        w_edge, w_active, w_timeout, w_complete;
    // r_sync[1:0] is the synchronizer, r_sync[2] the previous synchronized level
    assign w_edge     = r_sync[1] & ~r_sync[2];
    assign w_active   = (r_state == S_ARM) || (r_state == S_MEASURE);
    assign w_timeout  = w_active && (r_to_cnt == TIMEOUT_CYCLES - 1);
    assign w_complete = (r_state == S_MEASURE) && w_edge && (r_edge_cnt == N_PERIODS - 1);
    assign div_start  = (r_state == S_REQ);
    assign freq_valid = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    w_next = S_ARM;
            S_ARM:     w_next = w_timeout ? S_DONE : (w_edge ? S_MEASURE : S_ARM);
            S_MEASURE: w_next = w_complete ? S_REQ : (w_timeout ? S_DONE : S_MEASURE);
            S_REQ:     w_next = S_WAIT;
            S_WAIT:    w_next = div_ready ? S_DONE : S_WAIT;
            S_DONE:    w_next = S_ARM;
            default:   w_next = S_IDLE;
        endcase
        if (!enable) w_next = S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync       <= '0;
            r_cyc_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_to_cnt     <= '0;
            div_dividend <= '0;
            div_divisor  <= '0;
            freq_out     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            r_sync   <= {r_sync[1:0], sig_in};
            r_to_cnt <= w_active ? r_to_cnt + 32'd1 : '0;
            if (r_state == S_ARM && w_edge) begin
                r_cyc_cnt  <= '0;
                r_edge_cnt <= '0;
            end else if (r_state == S_MEASURE) begin
                r_cyc_cnt  <= (r_cyc_cnt == '1) ? r_cyc_cnt : r_cyc_cnt + 32'd1;
                r_edge_cnt <= r_edge_cnt + 32'(w_edge);
            end
            if (w_next == S_REQ) begin
                div_divisor  <= r_cyc_cnt + 32'd1;
                div_dividend <= DIVIDEND;
            end
            // DONE is only reached from a divider result (WAIT) or a timeout
            if (w_next == S_DONE) begin
                freq_out     <= (r_state == S_WAIT) ? div_quotient : '0;
                timeout_flag <= (r_state != S_WAIT);
            end
        end
    end
endmodule

// File: tb/tb_freq_recip_ctrl.sv
// tb_freq_recip_ctrl: directed bench with a 5-cycle rounding divider model.
module tb_freq_recip_ctrl;
    logic        clk = 1'b0;
    logic        rst, sig_in, enable, div_ready, div_start, freq_valid, busy, timeout_flag;
    logic [31:0] div_dividend, div_divisor, freq_out;
    logic [31:0] div_quotient = '0;
    logic [4:0]  sh = '0;
    logic        p_start = 1'b0, p_valid = 1'b0;
    int vectors = 0, errs = 0, sig_per = 0;
    int n_start = 0, n_valid = 0, dbl = 0;
    int s, v;

    always #5 clk = ~clk;

    freq_recip_ctrl #(.TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_ready(div_ready),
        .freq_out(freq_out), .freq_valid(freq_valid), .busy(busy), .timeout_flag(timeout_flag)
    );

    // divider: start in cycle T -> ready in cycle T+5, rounded quotient; not reset
    assign div_ready = sh[4];
    always @(posedge clk) begin
        sh <= {sh[3:0], div_start === 1'b1};
        if (div_start === 1'b1)
            div_quotient <= 32'((64'(div_dividend) + 64'(div_divisor / 2)) / 64'(div_divisor));
    end

    always @(posedge clk) begin
        if (div_start === 1'b1) n_start <= n_start + 1;
        if (freq_valid === 1'b1) n_valid <= n_valid + 1;
        if ((div_start === 1'b1 && p_start) || (freq_valid === 1'b1 && p_valid)) dbl <= dbl + 1;
        p_start <= (div_start === 1'b1);
        p_valid <= (freq_valid === 1'b1);
    end

    initial begin
        sig_in = 1'b0;
        forever begin
            if (sig_per == 0) begin
                sig_in = 1'b0;
                @(negedge clk);
            end else begin
                sig_in = 1'b1;
                repeat (sig_per / 2) @(negedge clk);
                sig_in = 1'b0;
                repeat (sig_per - sig_per / 2) @(negedge clk);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int k = 0;
        @(negedge clk);
        while (freq_valid !== 1'b1 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_seen"}, 32'(freq_valid === 1'b1), 32'd1);
    endtask

    task automatic restart(input int per);
        enable = 1'b0;
        sig_per = per;
        cyc(60);
        enable = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        cyc(3);
        chk("rst_freq_out", freq_out, 0);
        chk("rst_freq_valid", 32'(freq_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout_flag), 0);
        chk("rst_div_start", 32'(div_start), 0);
        chk("rst_dividend", div_dividend, 0);
        chk("rst_divisor", div_divisor, 0);
        rst = 1'b0;
        sig_per = 50;
        enable = 1'b1;
        wait_valid("p50", 2000);
        chk("p50_divisor", div_divisor, 500);
        chk("p50_dividend", div_dividend, 500_000_000);
        chk("p50_freq", freq_out, 1_000_000);
        chk("p50_timeout", 32'(timeout_flag), 0);
        cyc(1);
        chk("p50_valid_width", 32'(freq_valid), 0);
        s = n_start;
        v = n_valid;
        for (int i = 0; i < 3; i++) begin
            wait_valid("b2b", 2000);
            chk("b2b_freq", freq_out, 1_000_000);
        end
        cyc(1);
        chk("b2b_valid_count", 32'(n_valid - v), 3);
        chk("b2b_start_count", 32'(n_start - s), 3);
        restart(7);
        wait_valid("p7", 2000);
        chk("p7_divisor", div_divisor, 70);
        chk("p7_freq", freq_out, 7_142_857);
        restart(2);
        wait_valid("p2", 2000);
        chk("p2_divisor", div_divisor, 20);
        chk("p2_freq", freq_out, 25_000_000);
        restart(0);
        wait_valid("to", 2000);
        chk("to_freq", freq_out, 0);
        chk("to_flag", 32'(timeout_flag), 1);
        cyc(1);
        chk("to_rearm_busy", 32'(busy), 1);
        chk("to_valid_width", 32'(freq_valid), 0);
        v = n_valid;
        cyc(500);
        chk("to_valid_once", 32'(n_valid - v), 0);
        chk("to_still_busy", 32'(busy), 1);
        restart(50);
        cyc(200);
        s = n_start;
        v = n_valid;
        enable = 1'b0;
        cyc(1);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_freq_kept", freq_out, 0);
        chk("drop_flag_kept", 32'(timeout_flag), 1);
        cyc(20);
        chk("drop_no_start", 32'(n_start - s), 0);
        chk("drop_no_valid", 32'(n_valid - v), 0);
        enable = 1'b1;
        wait_valid("reen", 2000);
        chk("reen_freq", freq_out, 1_000_000);
        chk("reen_flag", 32'(timeout_flag), 0);
        begin
            int k = 0;
            while (div_start !== 1'b1 && k < 2000) begin
                @(negedge clk);
                k++;
            end
        end
        chk("mid_start_seen", 32'(div_start === 1'b1), 1);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_freq", freq_out, 0);
        chk("mid_rst_divisor", div_divisor, 0);
        chk("mid_rst_dividend", div_dividend, 0);
        chk("mid_rst_flag", 32'(timeout_flag), 0);
        chk("mid_rst_valid", 32'(freq_valid), 0);
        v = n_valid;
        rst = 1'b0;
        cyc(10);
        chk("late_ready_valid", 32'(n_valid - v), 0);
        chk("late_ready_freq", freq_out, 0);
        chk("pulse_width", 32'(dbl), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
